led_blinker: RTL
================

# led_blinker

Output-side counterpart to the button input chain. It takes single-cycle event pulses from core logic, one bit per channel, and turns each pulse into a distinct, human-visible LED blink of fixed on and off duration. Pulses that arrive while a channel is already blinking are counted and replayed as separate blinks, so no event is merged or lost until a saturating pending counter fills. It sits between the design's event logic and the board LED pins.

## Interface
- WIDTH, 1: number of independent channels.
- TICK_CNT_MAX, 62500: clk cycles per timing tick; must be ≥1. A value of 1 makes the tick fire every cycle.
- ON_TICKS, 200: ticks LED held high per blink; must be ≥1.
- OFF_TICKS, 200: ticks of forced low gap after each blink; must be ≥1.
- PEND_MAX, 7: maximum queued blinks per channel; must be ≥1.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset; asynchronous, active-high.
- pulse_in  in  WIDTH  one-cycle event requests, synchronous to clk.
- led_out  out  WIDTH  registered LED drive.
- busy  out  WIDTH  channel not IDLE.
- overflow  out  WIDTH  one-cycle pulse when a request is dropped.

## Operation
- Shared tick generator:
  - Counter runs 0..TICK_CNT_MAX-1 and wraps.
  - tick=1 when counter==TICK_CNT_MAX-1.
  - Counter width is $clog2(TICK_CNT_MAX), minimum 1.
- Per-channel FSM with states IDLE, ON and OFF, plus a phase counter and a pending counter (width $clog2(PEND_MAX+1)).
- Outputs: led_out=(state==ON); busy=(state!=IDLE); all are registered.
- IDLE:
  - pulse_in=1 → ON, phase=ON_TICKS-1. Pending is unchanged.
- ON:
  - On tick with phase==0 → OFF, phase=OFF_TICKS-1.
  - On tick otherwise, phase decrements.
- OFF:
  - On tick with phase==0:
    - If pending>0 or pulse_in=1 → ON, phase=ON_TICKS-1.
    - Otherwise → IDLE.
  - On tick otherwise, phase decrements.
- Pending update in ON/OFF, with "restart" meaning the OFF→ON transition in that cycle:
  - pulse_in=1, no restart: pending+1.
  - restart, pulse_in=0: pending-1.
  - restart with pulse_in=1 and pending>0: pending unchanged.
  - restart with pulse_in=1 and pending==0: pending stays 0; the pulse itself causes the restart.
- Saturation: pulse_in=1 in ON/OFF with pending==PEND_MAX and no restart in that cycle → request dropped, pending unchanged, overflow=1 on the next cycle only.
- Channels are fully independent; only the tick is shared.
- Reset mid-operation: all state clears immediately, including pending blinks, which are discarded. No blink resumes after release.

## Timing
- Reset values: led_out=0, busy=0, overflow=0, all FSMs IDLE, pending=0, phase=0, tick counter=0.
- Latency: pulse_in sampled high at edge k → led_out high from cycle k+1.
- With TICK_CNT_MAX=1:
  - ON lasts exactly ON_TICKS cycles; OFF lasts exactly OFF_TICKS cycles.
  - A back-to-back queued blink starts immediately after OFF, with no IDLE cycle.
- With TICK_CNT_MAX>1, ON duration lies in [(ON_TICKS-1)·TICK_CNT_MAX+1, ON_TICKS·TICK_CNT_MAX] cycles; OFF follows the same rule.
- pulse_in held high for n cycles counts as n requests.
- overflow asserts one cycle after the dropped request.

## Structure
- Shared package led_pkg:
  - FSM state encoding localparams (IDLE/ON/OFF, 2 bits).
  - Parameter-legality check macros.
- Sub-module led_channel: one FSM with its phase and pending counters, taking tick as an input. It is instantiated WIDTH times in a generate loop.
- Top-level led_blinker holds only the tick generator.

## Test plan
Parameters TICK_CNT_MAX=1, ON_TICKS=3, OFF_TICKS=2, PEND_MAX=2 unless stated.
- Reset: assert rst for 3 cycles, then pulse_in=0 → led_out, busy and overflow all 0; no activity for 20 cycles.
- Single blink: pulse_in[0] at cycle 0 → led_out[0] high cycles 1–3, low 4–5; busy[0] high cycles 1–5, low at cycle 6.
- Queued blinks: pulses at cycles 0, 1, 2 → ON 1–3, OFF 4–5, ON 6–8, OFF 9–10, ON 11–13, OFF 14–15; busy low at 16; overflow never set.
- Overflow plus seamless restart:
  - Pulses at cycles 0–3 → pulse at 3 is dropped, overflow[0] high at cycle 4 only; exactly three blinks occur.
  - Separately, a single pulse at 0 followed by a pulse at cycle 5 (last OFF cycle, pending 0) → ON 6–8 with busy continuous.
- Reset mid-blink / multi-channel: WIDTH=2; pulse channel 0 at 0 and 1, channel 1 at 1.
  - Channel 1 is ON 2–4, independent of channel 0.
  - rst asserted mid-cycle 2 → both led_out drop to 0 immediately; after release, no further blinks.
- Tick bounds: TICK_CNT_MAX=4, ON_TICKS=2, OFF_TICKS=1.
  - Pulses at varying phases relative to tick → every ON duration is within 5..8 cycles and every OFF duration within 1..4.

Source files
------------

// File: rtl/led_pkg.sv
// Shared definitions for the LED blinker: FSM state encoding, width helper
// and parameter-legality check macro.
`ifndef LED_PKG_SV
`define LED_PKG_SV

// Elaboration-time guard: fails the build when a parameter is below its minimum.
`define LED_CHECK_MIN(val, minv) \
  if ((val) < (minv)) begin \
    $error("led_blinker: parameter below its legal minimum"); \
  end

package led_pkg;

  localparam logic [1:0] LED_IDLE = 2'd0;
  localparam logic [1:0] LED_ON   = 2'd1;
  localparam logic [1:0] LED_OFF  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = LED_IDLE,
    ST_ON   = LED_ON,
    ST_OFF  = LED_OFF
  } led_state_t;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`endif

// File: rtl/led_channel.sv
// One LED channel: blink FSM with phase down-counter and saturating queue of
// pending blinks. Timing advances only on the shared tick.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | LED off, nothing queued, waiting for a pulse
// ST_ON   | LED lit for ON_TICKS ticks
// ST_OFF  | forced dark gap of OFF_TICKS ticks
module led_channel
  import led_pkg::*;
#(
  parameter int unsigned ON_TICKS  = 200,
  parameter int unsigned OFF_TICKS = 200,
  parameter int unsigned PEND_MAX  = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tick,
  input  logic i_pulse,
  output logic o_led,
  output logic o_busy,
  output logic o_overflow
);

  localparam int unsigned PH_W   = cnt_width((ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS);
  localparam int unsigned PEND_W = $clog2(PEND_MAX + 1);

  localparam logic [PH_W-1:0]   PH_ON_LOAD  = PH_W'(ON_TICKS - 1);
  localparam logic [PH_W-1:0]   PH_OFF_LOAD = PH_W'(OFF_TICKS - 1);
  localparam logic [PEND_W-1:0] PEND_FULL   = PEND_W'(PEND_MAX);

  led_state_t        r_state, w_state_nxt;
  logic [PH_W-1:0]   r_phase, w_phase_nxt;
  logic [PEND_W-1:0] r_pend, w_pend_nxt;
  logic              r_led, r_busy, r_ovf;
  logic              w_phase_zero, w_restart, w_drop;

  assign w_phase_zero = (r_phase == '0);
  // A queued blink (or a pulse landing right now) chains straight into ON.
  assign w_restart    = (r_state == ST_OFF) && i_tick && w_phase_zero &&
                        ((r_pend != '0) || i_pulse);

  // Registered state, counters and outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_phase <= '0;
      r_pend  <= '0;
      r_led   <= 1'b0;
      r_busy  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_pend  <= w_pend_nxt;
      r_led   <= (w_state_nxt == ST_ON);
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_ovf   <= w_drop;
    end
  end

  // Next state, phase countdown and pending-queue bookkeeping.
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_pend_nxt  = r_pend;
    w_drop      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_pulse) begin
          w_state_nxt = ST_ON;
          w_phase_nxt = PH_ON_LOAD;
        end
      end
      ST_ON: begin
        if (i_tick) begin
          if (w_phase_zero) begin
            w_state_nxt = ST_OFF;
            w_phase_nxt = PH_OFF_LOAD;
          end else begin
            w_phase_nxt = r_phase - PH_W'(1);
          end
        end
      end
      ST_OFF: begin
        if (i_tick) begin
          if (w_phase_zero) begin
            if (w_restart) begin
              w_state_nxt = ST_ON;
              w_phase_nxt = PH_ON_LOAD;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_phase_nxt = r_phase - PH_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // A restart consumes one queued blink unless this cycle's pulse supplies it.
    if (r_state != ST_IDLE) begin
      if (w_restart) begin
        if (!i_pulse) w_pend_nxt = r_pend - PEND_W'(1);
      end else if (i_pulse) begin
        if (r_pend == PEND_FULL) w_drop = 1'b1;
        else                     w_pend_nxt = r_pend + PEND_W'(1);
      end
    end
  end

  assign o_led      = r_led;
  assign o_busy     = r_busy;
  assign o_overflow = r_ovf;

endmodule

// File: rtl/led_blinker.sv
// LED blinker top: shared tick generator feeding WIDTH independent channels.
module led_blinker
  import led_pkg::*;
#(
  parameter int unsigned WIDTH        = 1,
  parameter int unsigned TICK_CNT_MAX = 62500,
  parameter int unsigned ON_TICKS     = 200,
  parameter int unsigned OFF_TICKS    = 200,
  parameter int unsigned PEND_MAX     = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pulse_in,
  output logic [WIDTH-1:0] led_out,
  output logic [WIDTH-1:0] busy,
  output logic [WIDTH-1:0] overflow
);

  `LED_CHECK_MIN(WIDTH, 1)
  `LED_CHECK_MIN(TICK_CNT_MAX, 1)
  `LED_CHECK_MIN(ON_TICKS, 1)
  `LED_CHECK_MIN(OFF_TICKS, 1)
  `LED_CHECK_MIN(PEND_MAX, 1)

  localparam int unsigned TC_W = cnt_width(TICK_CNT_MAX);
  localparam logic [TC_W-1:0] TC_LAST = TC_W'(TICK_CNT_MAX - 1);

  logic [TC_W-1:0] r_tick_cnt;
  logic            w_tick;

  assign w_tick = (r_tick_cnt == TC_LAST);

  // Free-running tick prescaler, wraps on the terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + TC_W'(1);
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
    led_channel #(
      .ON_TICKS (ON_TICKS),
      .OFF_TICKS(OFF_TICKS),
      .PEND_MAX (PEND_MAX)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .i_tick    (w_tick),
      .i_pulse   (pulse_in[gi]),
      .o_led     (led_out[gi]),
      .o_busy    (busy[gi]),
      .o_overflow(overflow[gi])
    );
  end

endmodule
